// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the parametrised VGA timing generator.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam bit POL_LOW  = 1'b0;
  localparam bit POL_HIGH = 1'b1;

  function automatic int axis_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

  function automatic bit in_window(
    input int v,
    input int lo,
    input int len
  );
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One-dimensional wrap counter with next-state phase decode;
// decodes look at the value the counter is about to hold.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int CNT_W      = 10,
  parameter int TOTAL      = 800,
  parameter int ACTIVE     = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_LEN   = 96
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             active_nxt,
  output logic             sync_nxt,
  output logic             blank_start_nxt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] BLANK_AT = CNT_W'(ACTIVE);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    wrap  = adv && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (adv) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end
    active_nxt      = in_window(int'(cnt_d), 0, ACTIVE);
    sync_nxt        = in_window(int'(cnt_d), SYNC_START, SYNC_LEN);
    blank_start_nxt = (cnt_d == BLANK_AT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= LAST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vga_timing_gen_param.sv
// Parametrised VGA timing generator: counters, syncs, data enable,
// line/frame strobes and frame counter, all advancing on pix_ce.
module vga_timing_gen_param
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter bit HSYNC_POL   = POL_LOW,
  parameter bit VSYNC_POL   = POL_LOW,
  parameter int CNT_W       = 10,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pix_ce,
  output logic [CNT_W-1:0]       col,
  output logic [CNT_W-1:0]       row,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   data_enable,
  output logic                   line_pulse,
  output logic                   frame_pulse,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

  if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
      V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_timing
    $error("vga_timing_gen_param: timing parameters must be non-zero");
  end
  if (FRAME_CNT_W <= 0 || CNT_W <= 0 || $clog2(MAX_TOTAL) > CNT_W) begin : g_bad_width
    $error("vga_timing_gen_param: CNT_W too small for H_TOTAL/V_TOTAL");
  end

  logic h_wrap, h_act_n, h_sync_n, h_bs_n;
  logic v_wrap, v_act_n, v_sync_n, v_bs_n;

  vga_axis_counter #(
    .CNT_W      (CNT_W),
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_LEN   (H_SYNC)
  ) u_h (
    .clk             (clk),
    .reset           (reset),
    .adv             (pix_ce),
    .cnt             (col),
    .wrap            (h_wrap),
    .active_nxt      (h_act_n),
    .sync_nxt        (h_sync_n),
    .blank_start_nxt (h_bs_n)
  );

  vga_axis_counter #(
    .CNT_W      (CNT_W),
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_LEN   (V_SYNC)
  ) u_v (
    .clk             (clk),
    .reset           (reset),
    .adv             (h_wrap),
    .cnt             (row),
    .wrap            (v_wrap),
    .active_nxt      (v_act_n),
    .sync_nxt        (v_sync_n),
    .blank_start_nxt (v_bs_n)
  );

  logic                   hsync_q, hsync_d;
  logic                   vsync_q, vsync_d;
  logic                   de_q, de_d;
  logic                   line_pulse_q, line_pulse_d;
  logic                   frame_pulse_q, frame_pulse_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

  // Next-state decodes keep the syncs aligned with the registered counters.
  always_comb begin
    hsync_d       = h_sync_n ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = v_sync_n ? VSYNC_POL : ~VSYNC_POL;
    de_d          = h_act_n & v_act_n;
    line_pulse_d  = pix_ce & h_bs_n;
    frame_pulse_d = h_wrap & v_bs_n;
    frame_count_d = frame_count_q;
    if (h_wrap && v_wrap) begin
      frame_count_d = frame_count_q + FRAME_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      de_q          <= 1'b0;
      line_pulse_q  <= 1'b0;
      frame_pulse_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      line_pulse_q  <= line_pulse_d;
      frame_pulse_q <= frame_pulse_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign data_enable = de_q;
  assign line_pulse  = line_pulse_q;
  assign frame_pulse = frame_pulse_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen_param.sv
// Scoreboard bench for vga_timing_gen_param on a small 14x7 timing set
// with active-high syncs and a 2-bit frame counter.
module tb_vga_timing_gen_param;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int CW = 4, FW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pix_ce = 1'b0;
  logic [CW-1:0] col, row;
  logic          hsync, vsync, data_enable, line_pulse, frame_pulse;
  logic [FW-1:0] frame_count;

  vga_timing_gen_param #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
    .CNT_W(CW), .FRAME_CNT_W(FW)
  ) dut (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .col(col), .row(row),
    .hsync(hsync), .vsync(vsync),
    .data_enable(data_enable),
    .line_pulse(line_pulse), .frame_pulse(frame_pulse),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic          hs;
    logic          vs;
    logic          de;
    logic          lp;
    logic          fp;
    logic [FW-1:0] fc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int m_col = HT - 1;
  int m_row = VT - 1;
  int m_fc = 0;
  int cyc = 0;
  int last_fp = -1;
  int lp_cnt = 0;
  int exp_period = 0;
  logic prev_lp = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input bit rst, input bit ce);
    exp_t e;
    @(negedge clk);
    reset  = rst;
    pix_ce = ce;
    e.lp = 1'b0;
    e.fp = 1'b0;
    if (rst) begin
      m_col = HT - 1;
      m_row = VT - 1;
      m_fc  = 0;
    end else if (ce) begin
      m_col++;
      if (m_col == HT) begin
        m_col = 0;
        m_row++;
        if (m_row == VT) m_row = 0;
      end
      if (m_col == 0 && m_row == 0) m_fc = (m_fc + 1) % (1 << FW);
      e.lp = (m_col == HA);
      e.fp = (m_col == 0 && m_row == VA);
    end
    e.col = CW'(m_col);
    e.row = CW'(m_row);
    e.hs  = (m_col >= HA + HF) && (m_col < HA + HF + HS);
    e.vs  = (m_row >= VA + VF) && (m_row < VA + VF + VS);
    e.de  = (m_col < HA) && (m_row < VA);
    e.fc  = FW'(m_fc);
    q.push_back(e);
  endtask

  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("col", 32'(col), 32'(e.col));
      check("row", 32'(row), 32'(e.row));
      check("hsync", 32'(hsync), 32'(e.hs));
      check("vsync", 32'(vsync), 32'(e.vs));
      check("data_enable", 32'(data_enable), 32'(e.de));
      check("line_pulse", 32'(line_pulse), 32'(e.lp));
      check("frame_pulse", 32'(frame_pulse), 32'(e.fp));
      check("frame_count", 32'(frame_count), 32'(e.fc));
      check("lp_double", 32'(line_pulse & prev_lp), 32'd0);
      prev_lp = line_pulse;
      if (line_pulse) lp_cnt++;
      if (frame_pulse) begin
        if (last_fp >= 0 && exp_period > 0) begin
          check("frame_period", 32'(cyc - last_fp), 32'(exp_period));
          check("lines_per_frame", 32'(lp_cnt), 32'(VT));
        end
        last_fp = cyc;
        lp_cnt  = 0;
      end
    end
  end

  initial begin
    repeat (3) step(1'b1, 1'b0);

    exp_period = HT * VT;
    last_fp    = -1;
    repeat (3 * HT * VT + 5) step(1'b0, 1'b1);

    exp_period = 0;
    for (int i = 0; i < 200 && !(m_row == 3 && m_col == 5); i++)
      step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    last_fp    = -1;
    exp_period = 4 * HT * VT;
    repeat (2 * HT * VT + 3) begin
      step(1'b0, 1'b1);
      repeat (3) step(1'b0, 1'b0);
    end

    exp_period = 0;
    repeat (600) step(1'b0, 1'($urandom_range(0, 1)));

    step(1'b1, 1'b0);
    last_fp    = -1;
    exp_period = HT * VT;
    repeat (5 * HT * VT + 10) step(1'b0, 1'b1);

    @(posedge clk);
    #2;
    check("queue_drain", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
